// File: rtl/uart_rx_fnd_multi.sv
// UART 8N1 receiver with a NUM_BYTES-deep history shown as hex digits on 7-segment displays.
// Defining RX_PARITY_EN switches the frame format to 8E1 with parity-error reporting.
module uart_rx_fnd_multi #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 2
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic                    i_Rx,
    output logic                    o_fDone,
    output logic                    o_fErr,
    output logic [7:0]              o_RxData,
    output logic [14*NUM_BYTES-1:0] o_Seg
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t         state_reg;
    logic [CW-1:0]  cnt_reg;
    logic [2:0]     bit_idx_reg;
    logic [7:0]     shift_reg;
    logic           rx_meta_reg;
    logic           rx_s_reg;
    logic           fdone_reg;
    logic           ferr_reg;
    logic [7:0]     rx_data_reg;
    logic [7:0]     hist_reg [NUM_BYTES];
    logic [NUM_BYTES-1:0] valid_reg;
    logic           parity_ok;

`ifdef RX_PARITY_EN
    logic           parity_reg;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_ok = ~(^{shift_reg, parity_reg});
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            fdone_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            rx_data_reg <= 8'h00;
            valid_reg   <= '0;
            for (int k = 0; k < NUM_BYTES; k++) hist_reg[k] <= 8'h00;
`ifdef RX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            rx_meta_reg <= i_Rx;
            rx_s_reg    <= rx_meta_reg;
            fdone_reg   <= 1'b0;
            ferr_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!rx_s_reg) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= rx_s_reg ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg     <= '0;
                        shift_reg   <= {rx_s_reg, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == 3'd7) begin
`ifdef RX_PARITY_EN
                            state_reg <= PARITY;
`else
                            state_reg <= STOP;
`endif
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg    <= '0;
                        parity_reg <= rx_s_reg;
                        state_reg  <= STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg <= '0;
                        // A low stop bit wins over a parity error: the line may be in a break.
                        if (!rx_s_reg) begin
                            ferr_reg  <= 1'b1;
                            state_reg <= BREAK;
                        end else if (!parity_ok) begin
                            ferr_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            fdone_reg   <= 1'b1;
                            rx_data_reg <= shift_reg;
                            for (int k = NUM_BYTES - 1; k > 0; k--) begin
                                hist_reg[k]  <= hist_reg[k-1];
                                valid_reg[k] <= valid_reg[k-1];
                            end
                            hist_reg[0]  <= shift_reg;
                            valid_reg[0] <= 1'b1;
                            state_reg    <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s_reg) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_fDone  = fdone_reg;
    assign o_fErr   = ferr_reg;
    assign o_RxData = rx_data_reg;

    // Active-low {g,f,e,d,c,b,a} hex patterns.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        case (nib)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_slot
            assign o_Seg[14*gi +: 14] = valid_reg[gi]
                ? {hex7(hist_reg[gi][7:4]), hex7(hist_reg[gi][3:0])}
                : 14'h3FFF;
        end
    endgenerate

endmodule

// File: tb/tb_uart_rx_fnd_multi.sv
// Self-checking bench for uart_rx_fnd_multi: directed frames plus random bytes against a queue-based history model.
module tb_uart_rx_fnd_multi;

    localparam int CPB = 16;
    localparam int NB  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rx = 1'b1;
    logic           fdone;
    logic           ferr;
    logic [7:0]     rxdata;
    logic [14*NB-1:0] seg;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] pulse_data = 8'h00;

    logic [7:0] hist_q [$];
    logic [7:0] model_data = 8'h00;
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    uart_rx_fnd_multi #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut (
        .i_Clk    (clk),
        .i_Rst    (rst_n),
        .i_Rx     (rx),
        .o_fDone  (fdone),
        .o_fErr   (ferr),
        .o_RxData (rxdata),
        .o_Seg    (seg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fdone) begin
            done_cnt++;
            pulse_data = rxdata;
        end
        if (ferr) err_cnt++;
        if (fdone || ferr) begin
            checks++;
            assert (!(fdone && ferr)) else begin
                errors++;
                $error("FAIL both_pulses observed fdone=%0b ferr=%0b expected not both", fdone, ferr);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [14*NB-1:0] model_seg();
        logic [14*NB-1:0] s;
        s = '1;
        for (int k = 0; k < NB; k++) begin
            if (k < hist_q.size())
                s[14*k +: 14] = {seg_tab[hist_q[k][7:4]], seg_tab[hist_q[k][3:0]]};
        end
        return s;
    endfunction

    task automatic model_accept(input logic [7:0] d);
        hist_q.push_front(d);
        if (hist_q.size() > NB) void'(hist_q.pop_back());
        model_data = d;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        drive_bit(stop_bit);
    endtask

    // Sends a frame, optionally holds the line low afterwards, updates the model and checks.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic stop_bit,
                             input logic par_flip, input int low_hold);
        int d0, e0;
        logic good;
        d0 = done_cnt;
        e0 = err_cnt;
        good = stop_bit && !par_flip;
        send_frame(d, stop_bit, par_flip);
        if (low_hold > 0) begin
            rx = 1'b0;
            repeat (low_hold) @(negedge clk);
        end
        rx = 1'b1;
        if (good) model_accept(d);
        $display("frame %s data=%h stop=%0b parflip=%0b good=%0b", tag, d, stop_bit, par_flip, good);
        check({tag, "_done"}, 64'(done_cnt - d0), good ? 64'd1 : 64'd0);
        check({tag, "_err"},  64'(err_cnt - e0),  good ? 64'd0 : 64'd1);
        check({tag, "_data"}, 64'(rxdata), 64'(model_data));
        check({tag, "_seg"},  64'(seg), 64'(model_seg()));
        if (good) check({tag, "_pulse_data"}, 64'(pulse_data), 64'(d));
    endtask

    initial begin
        int d0, e0;
        logic [7:0] b;
        logic bad;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_seg", 64'(seg), 64'h0FFF_FFFF);
        check("rst_data", 64'(rxdata), 64'h00);
        check("rst_done", 64'(fdone), 64'd0);
        check("rst_err", 64'(ferr), 64'd0);
        rst_n = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        idle(3 * CPB);
        check("idle_seg", 64'(seg), 64'h0FFF_FFFF);
        check("idle_pulses", 64'(done_cnt - d0 + err_cnt - e0), 64'd0);

        // Single byte, then back-to-back bytes
        run_frame("b3A", 8'h3A, 1'b1, 1'b0, 0);
        check("b3A_const", 64'(seg), 64'({14'h3FFF, 7'h30, 7'h08}));
        run_frame("bF0", 8'hF0, 1'b1, 1'b0, 0);
        check("bF0_const", 64'(seg), 64'({7'h30, 7'h08, 7'h0E, 7'h40}));
        run_frame("b00", 8'h00, 1'b1, 1'b0, 0);
        idle(CPB);

        // Framing error with the line held low, then recovery
        run_frame("brk55", 8'h55, 1'b0, 1'b0, 40);
        idle(CPB);
        run_frame("b12", 8'h12, 1'b1, 1'b0, 0);
        idle(CPB);

        // Short glitch on an idle line
        d0 = done_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * CPB);
        $display("glitch 4 cycles");
        check("glitch_pulses", 64'(done_cnt - d0 + err_cnt - e0), 64'd0);
        check("glitch_seg", 64'(seg), 64'(model_seg()));
        run_frame("post_glitch", 8'hC7, 1'b1, 1'b0, 0);
        idle(CPB);

`ifdef RX_PARITY_EN
        run_frame("par_ok07", 8'h07, 1'b1, 1'b0, 0);
        idle(CPB);
        run_frame("par_bad07", 8'h07, 1'b1, 1'b1, 0);
        idle(CPB);
        run_frame("par_after", 8'h9E, 1'b1, 1'b0, 0);
        idle(CPB);
`endif

        // Reset during the data phase
        d0 = done_cnt;
        e0 = err_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hist_q.delete();
        model_data = 8'h00;
        idle(2 * CPB);
        $display("reset mid-frame");
        check("midrst_pulses", 64'(done_cnt - d0 + err_cnt - e0), 64'd0);
        check("midrst_seg", 64'(seg), 64'h0FFF_FFFF);
        check("midrst_data", 64'(rxdata), 64'h00);
        run_frame("bA5", 8'hA5, 1'b1, 1'b0, 0);
        idle(CPB);

        // Random bytes with occasional framing errors
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            run_frame("rnd", b, !bad, 1'b0, bad ? 20 : 0);
            idle(bad ? CPB : CPB * $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_fnd_multi.md
# uart_rx_fnd_multi

Parametrised UART receive-and-display block: receives 8-bit serial frames on a single line and keeps a history of the last NUM_BYTES bytes, each shown as two hexadecimal 7-segment digits. Successor to the fixed single-byte receiver/FND pair. Adds:
- a configurable baud divisor;
- a multi-byte display history with per-slot blanking;
- frame-error detection and recovery;
- optional parity checking.

Sits between the board RX pin and the FND driver pins.

## Interface
- CLKS_PER_BIT, 868: clock cycles per UART bit; legal range ≥ 4.
- NUM_BYTES, 2: number of received bytes held and displayed; legal range 1..8.

- i_Clk  in  1  system clock; all state is updated on the rising edge.
- i_Rst  in  1  reset, synchronous, active-low.
- i_Rx  in  1  asynchronous serial input; idles high.
- o_fDone  out  1  one-cycle pulse when a valid byte is accepted.
- o_fErr  out  1  one-cycle pulse on a framing error (or a parity error, see Configuration).
- o_RxData  out  8  last accepted byte.
- o_Seg  out  14*NUM_BYTES  segment outputs. Slot k occupies bits [14k+13:14k]: high nibble in the upper 7 bits, low nibble in the lower 7 bits. Each digit is ordered {g,f,e,d,c,b,a}, active-low.

## Operation
- i_Rx passes through a 2-flop synchronizer; the FSM uses only the synchronized value rx_s.
- FSM states and transitions:
  - IDLE: on rx_s == 0, go to START and clear the counter.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s.
    - If 0, go to DATA.
    - If 1, treat as a glitch and return to IDLE with no error.
  - DATA: sample 8 bits, LSB first, one sample every CLKS_PER_BIT cycles. Then go to PARITY (if enabled) or STOP.
  - PARITY: sample one bit CLKS_PER_BIT cycles later.
  - STOP: sample CLKS_PER_BIT cycles after the previous sample.
    - If 1, the frame is accepted; go to IDLE.
    - If 0, pulse o_fErr and go to BREAK.
  - BREAK: wait for rx_s == 1, then go to IDLE. While the line is held low, no new start bit is detected.
- Accepting a byte:
  - o_RxData takes the byte.
  - The history shifts: slot k+1 ← slot k, slot 0 ← new byte, and the oldest byte is dropped.
  - The valid bit of every occupied slot shifts the same way.
- Display:
  - A slot whose valid bit is 0 drives 7'h7F on both digits (blank).
  - A valid slot drives the standard hex digit patterns: 0=7'h40, 3=7'h30, A=7'h08, F=7'h0E.
  - Decode is combinational from the registered history and valid bits.
- Errored frames (stop or parity) never modify o_RxData, the history or the valid bits.

## Timing
- Reset values while i_Rst is sampled low:
  - FSM = IDLE; counter and bit index cleared.
  - Sync flops set to 1.
  - o_fDone = 0, o_fErr = 0, o_RxData = 8'h00.
  - All valid bits = 0, so o_Seg is all ones.
- Reset asserted mid-frame aborts the frame with no pulse. The next frame is received normally.
- Latency from i_Rx falling to START entry: 2 synchronizer cycles plus 1 FSM cycle.
- Sample schedule:
  - Start-bit sample: CLKS_PER_BIT/2 cycles after START entry.
  - Data bit n: (n+1)*CLKS_PER_BIT cycles after the start-bit sample.
  - Stop bit: 9*CLKS_PER_BIT after the start-bit sample (10*CLKS_PER_BIT with parity).
- o_fDone or o_fErr is high for exactly the one cycle after the stop/parity decision edge. In that same cycle, o_RxData and o_Seg show the new values.
- Back-to-back frames: a start bit that immediately follows a stop bit is detected with no lost cycles, because STOP returns directly to IDLE.
- o_fDone and o_fErr are never high in the same cycle.

## Configuration
- RX_PARITY_EN defined:
  - Frame format is 8E1: an even-parity bit sits between data bit 7 and the stop bit.
  - On a parity mismatch with a good stop bit: o_fErr pulses, the byte is discarded, and the FSM returns to IDLE.
  - If the stop bit is also 0, the framing-error path (BREAK) takes precedence.
- RX_PARITY_EN undefined:
  - Frame format is 8N1, the PARITY state is removed, and stop-bit timing is 9*CLKS_PER_BIT.

## Test plan
All scenarios use CLKS_PER_BIT=16 and NUM_BYTES=2 unless stated otherwise.
- Reset then idle line → o_Seg = 28'hFFFFFFF, o_RxData = 8'h00, no pulses.
- Send 8'h3A → one o_fDone pulse; o_RxData = 8'h3A; slot0 = {7'h30, 7'h08}; slot1 blank (7'h7F, 7'h7F).
- Send 8'h3A, then 8'hF0, back-to-back → two o_fDone pulses; slot0 = {7'h0E, 7'h40}; slot1 = {7'h30, 7'h08}.
  - A third byte 8'h00 then shifts 8'hF0 into slot1.
- Send 8'h55 with the stop bit forced low, holding the line low for 40 cycles, then send 8'h12:
  - First frame: o_fErr pulse, no o_fDone, history unchanged.
  - 8'h12 is then accepted normally.
- Low pulse of 4 cycles on an idle line → no o_fDone and no o_fErr; FSM back in IDLE.
- RX_PARITY_EN build:
  - 8'h07 with parity bit 1 → o_fDone.
  - 8'h07 with parity bit 0 → o_fErr, o_RxData unchanged.
- Assert i_Rst during DATA of a frame → no pulse; a following 8'hA5 frame is received correctly.
